// File: rtl/verilogicoin_pkg.sv
// Shared definitions for the key-verification scheduler and its hash engine.
// Provides the requester count, permutation-table width, the accepted key tag,
// the hash length in engine cycles, the scheduler state encodings and the
// packed layout of a public key.
package verilogicoin_pkg;

  localparam int NUM_REQ     = 4;
  localparam int TABLE_W     = 258;
  localparam int HASH_CYCLES = 8;

  localparam logic [3:0] KEY_TAG = 4'b0010;

  // Scheduler states (3-bit encoding).
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_HASH    = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  // Public key: upper nibble is the tag, lower byte the expected hash.
  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] hash;
  } pub_key_t;

endpackage

// File: rtl/pearson_hash8.sv
// Eight-round Pearson-style hash engine.
// Ports:
//   clock        system clock (rising edge)
//   resetn       asynchronous active-low restart; clears counter and hash
//   message      8-bit key being hashed, held stable while hashing
//   random_table [255:0] = 32 one-byte table entries, [257:256] = rotate amount
//   counter      round counter, 0..7, advancing every cycle out of reset
//   hash         running hash; holds the full result once counter wraps to 0
module pearson_hash8
  import verilogicoin_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic [7:0]         message,
  input  logic [TABLE_W-1:0] random_table,
  output logic [2:0]         counter,
  output logic [7:0]         hash
);

  logic [7:0] mix;
  logic [7:0] entry;
  logic [7:0] folded;
  logic [7:0] hash_next;

  always_comb begin
    // The round number is mixed in so identical rounds do not collapse.
    mix    = hash ^ message ^ {5'b0, counter};
    entry  = random_table[{mix[4:0], 3'b000} +: 8];
    // Fold the address bits the 32-entry table cannot see back in.
    folded = entry ^ {mix[7:5], 5'b0};
    case (random_table[TABLE_W-1 -: 2])
      2'd0:    hash_next = folded;
      2'd1:    hash_next = {folded[6:0], folded[7]};
      2'd2:    hash_next = {folded[5:0], folded[7:6]};
      default: hash_next = {folded[4:0], folded[7:5]};
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      counter <= '0;
      hash    <= '0;
    end else begin
      counter <= counter + 3'd1;
      hash    <= hash_next;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin selection.
// Ports:
//   req    request vector
//   rr_ptr highest-priority requester index
//   grant  one-hot winner (zero when no request)
//   index  binary index of the winner
//   valid  any request present
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic [3:0] grant,
  output logic [1:0] index,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    grant = '0;
    index = rr_ptr;
    valid = 1'b0;
    cand  = '0;
    // Scan from the farthest offset down so the nearest set bit to rr_ptr
    // is the last one written and therefore wins.
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (req[cand]) begin
        grant = 4'b0001 << cand;
        index = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/verify_scheduler.sv
// Round-robin scheduler sharing one pearson_hash8 engine among four
// key-verification requesters.
// Ports:
//   clock, resetn     system clock and asynchronous active-low reset
//   req               level requests, held until the requester's done
//   public_key_flat   requester i public key {tag, hash} at [12i+11:12i]
//   input_key_flat    requester i candidate key at [8i+7:8i]
//   random_table      permutation table forwarded to the engine
//   grant             one-hot engine owner, zero when idle
//   busy              high outside IDLE
//   done              one-cycle pulse on the owner's bit at the end
//   correct           verdict, only meaningful while done is non-zero
//   tag_err           set with done when the owner's tag was not accepted
module verify_scheduler
  import verilogicoin_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [12*NUM_REQ-1:0] public_key_flat,
  input  logic [8*NUM_REQ-1:0] input_key_flat,
  input  logic [TABLE_W-1:0]   random_table,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [NUM_REQ-1:0]   done,
  output logic                 correct,
  output logic                 tag_err
);

  pub_key_t   pub_keys [NUM_REQ];
  logic [7:0] in_keys  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operands
    assign pub_keys[gi] = public_key_flat[12*gi +: 12];
    assign in_keys[gi]  = input_key_flat[8*gi +: 8];
  end

  logic [2:0] state_reg, state_next;
  logic [3:0] grant_reg;
  logic [1:0] index_reg;
  logic [1:0] rr_ptr_reg;
  logic [7:0] key_reg;
  logic [7:0] exp_hash_reg;
  logic       tag_err_reg;
  logic       match_reg;
  logic       eng_en_reg;

  logic [3:0] arb_grant;
  logic [1:0] arb_index;
  logic       arb_valid;

  logic [2:0] eng_counter;
  logic [7:0] eng_hash;
  logic       eng_resetn;
  logic       sel_tag_ok;

  rr_arbiter4 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .grant  (arb_grant),
    .index  (arb_index),
    .valid  (arb_valid)
  );

  // The engine enable is a flop, so the engine's asynchronous reset only
  // sees clean edges. It stays high through COMPARE so the finished hash is
  // still present when it is compared.
  assign eng_resetn = resetn & eng_en_reg;

  pearson_hash8 u_hash (
    .clock        (clock),
    .resetn       (eng_resetn),
    .message      (key_reg),
    .random_table (random_table),
    .counter      (eng_counter),
    .hash         (eng_hash)
  );

  assign sel_tag_ok = (pub_keys[arb_index].tag == KEY_TAG);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (arb_valid) state_next = sel_tag_ok ? ST_LOAD : ST_RESP;
      ST_LOAD:    state_next = ST_HASH;
      ST_HASH:    if (eng_counter == 3'(HASH_CYCLES - 1)) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      index_reg    <= '0;
      rr_ptr_reg   <= '0;
      key_reg      <= '0;
      exp_hash_reg <= '0;
      tag_err_reg  <= 1'b0;
      match_reg    <= 1'b0;
      eng_en_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      eng_en_reg <= (state_next == ST_HASH) || (state_next == ST_COMPARE);
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_reg    <= arb_grant;
            index_reg    <= arb_index;
            key_reg      <= in_keys[arb_index];
            exp_hash_reg <= pub_keys[arb_index].hash;
            tag_err_reg  <= ~sel_tag_ok;
            match_reg    <= 1'b0;
          end
        end
        ST_COMPARE: match_reg <= (eng_hash == exp_hash_reg);
        ST_RESP: begin
          rr_ptr_reg <= index_reg + 2'd1;
          grant_reg  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant   = grant_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_RESP) ? grant_reg : '0;
  assign correct = (state_reg == ST_RESP) & match_reg & ~tag_err_reg;
  assign tag_err = (state_reg == ST_RESP) & tag_err_reg;

endmodule

// File: tb/tb_verify_scheduler.sv
module tb_verify_scheduler;
  import verilogicoin_pkg::*;

  logic               clock = 1'b0;
  logic               resetn;
  logic [3:0]         req;
  logic [47:0]        public_key_flat;
  logic [31:0]        input_key_flat;
  logic [TABLE_W-1:0] random_table;
  logic [3:0]         grant;
  logic               busy;
  logic [3:0]         done;
  logic               correct;
  logic               tag_err;

  int errors = 0;
  int checks = 0;
  logic [1:0] model_ptr;

  always #5 clock = ~clock;

  verify_scheduler dut (
    .clock           (clock),
    .resetn          (resetn),
    .req             (req),
    .public_key_flat (public_key_flat),
    .input_key_flat  (input_key_flat),
    .random_table    (random_table),
    .grant           (grant),
    .busy            (busy),
    .done            (done),
    .correct         (correct),
    .tag_err         (tag_err)
  );

  // Reference hash: eight table rounds as described for the engine.
  function automatic logic [7:0] ref_hash(input logic [7:0] msg);
    logic [7:0]  h;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [15:0] dbl;
    int          rot;
    h   = 8'h00;
    rot = int'(random_table[TABLE_W-1 -: 2]);
    for (int c = 0; c < 8; c++) begin
      x   = h ^ msg ^ 8'(c);
      b   = random_table[int'(x[4:0]) * 8 +: 8] ^ {x[7:5], 5'b0};
      dbl = {b, b} << rot;
      h   = dbl[15:8];
    end
    return h;
  endfunction

  function automatic int pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] j;
    for (int off = 0; off < 4; off++) begin
      j = ptr + 2'(off);
      if (mask[j]) return int'(j);
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_keys(input int r, input logic [3:0] tag, input logic [7:0] h,
                          input logic [7:0] k);
    public_key_flat[12*r +: 12] = {tag, h};
    input_key_flat[8*r +: 8]    = k;
  endtask

  // One transaction: present mask in an IDLE cycle (cycle 0) and follow it to done.
  task automatic run_op(input logic [3:0] mask, input int exp_owner, input int exp_lat,
                        input logic exp_tag, input logic exp_corr, input bit scramble);
    int         lat;
    logic [3:0] d;
    logic       c;
    logic       t;
    logic [3:0] eg;
    lat = -1;
    d   = '0;
    c   = 1'b0;
    t   = 1'b0;
    eg  = 4'b0001 << exp_owner;
    @(negedge clock);
    req = mask;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("grant_c1", grant, eg);
        check("busy_c1", busy, 1);
      end
      if (scramble && k == 5) begin
        set_keys(exp_owner, 4'($urandom), 8'($urandom), 8'($urandom));
        req = '0;
      end
      if (done != 0) begin
        lat = k;
        d   = done;
        c   = correct;
        t   = tag_err;
        req = '0;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("done_owner", d, eg);
    check("correct", c, exp_corr);
    check("tag_err", t, exp_tag);
    $display("op mask=%b owner=%0d lat=%0d done=%b correct=%b tag_err=%b",
             mask, exp_owner, lat, d, c, t);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
    model_ptr = 2'(exp_owner + 1);
  endtask

  initial begin
    logic [7:0] k8;
    logic [3:0] mask;
    logic [3:0] exp_d;
    logic [3:0] tags [4];
    logic       good [4];
    int         owner;
    int         seen;

    resetn = 1'b0;
    req = '0;
    public_key_flat = '0;
    input_key_flat = '0;
    for (int i = 0; i < TABLE_W; i++) random_table[i] = 1'($urandom);
    model_ptr = 2'd0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_correct", correct, 0);
    check("rst_tag_err", tag_err, 0);
    resetn = 1'b1;

    // Matching hash on requester 0
    set_keys(0, KEY_TAG, ref_hash(8'h5A), 8'h5A);
    run_op(4'b0001, 0, 11, 1'b0, 1'b1, 1'b0);

    // Expected hash off by one
    set_keys(0, KEY_TAG, ref_hash(8'h5A) + 8'd1, 8'h5A);
    run_op(4'b0001, 0, 11, 1'b0, 1'b0, 1'b0);

    // Wrong tag on requester 2
    set_keys(2, 4'b0011, ref_hash(8'h33), 8'h33);
    run_op(4'b0100, 2, 1, 1'b1, 1'b0, 1'b0);

    // Reset during HASH
    set_keys(0, KEY_TAG, ref_hash(8'h11), 8'h11);
    @(negedge clock);
    req = 4'b0001;
    repeat (5) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_correct", correct, 0);
    req = '0;
    repeat (3) begin
      @(negedge clock);
      check("midrst_no_done", done, 0);
    end
    resetn = 1'b1;
    model_ptr = 2'd0;
    $display("op reset asserted during HASH");

    // All four requesting continuously: 0,1,2,3,0 every 12 cycles
    for (int r = 0; r < 4; r++) begin
      k8 = 8'($urandom);
      set_keys(r, KEY_TAG, ref_hash(k8), k8);
    end
    seen = 0;
    @(negedge clock);
    req = 4'hF;
    for (int k = 1; k <= 80 && seen < 5; k++) begin
      @(negedge clock);
      if (done != 0) begin
        exp_d = 4'b0001 << (seen % 4);
        check("rr_done", done, exp_d);
        check("rr_cycle", k, 11 + 12 * seen);
        check("rr_correct", correct, 1);
        $display("op mask=1111 done=%b cycle=%0d correct=%b", done, k, correct);
        seen++;
        if (seen == 5) req = '0;
      end
    end
    check("rr_count", seen, 5);
    @(negedge clock);
    check("rr_idle", busy, 0);
    model_ptr = 2'd1;

    // Requester 1 scrambles its operands and drops req mid-hash
    set_keys(1, KEY_TAG, ref_hash(8'hC3), 8'hC3);
    run_op(4'b0010, 1, 11, 1'b0, 1'b1, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 20; i++) begin
      mask = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++) begin
        k8 = 8'($urandom);
        tags[r] = ($urandom % 4 != 0) ? KEY_TAG : (4'($urandom) | 4'b1000);
        good[r] = 1'($urandom);
        set_keys(r, tags[r],
                 good[r] ? ref_hash(k8) : (ref_hash(k8) ^ 8'($urandom_range(1, 255))), k8);
      end
      owner = pick(mask, model_ptr);
      run_op(mask, owner, (tags[owner] == KEY_TAG) ? 11 : 1,
             tags[owner] != KEY_TAG, (tags[owner] == KEY_TAG) && good[owner], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
